// File: rtl/serial_addsub_if.sv
// Operand/result handshake bundle for the bit-serial adder/subtractor.
//   in_valid/in_ready : operand handshake (op, op_a, op_b travel with it)
//   out_valid/out_ready : result handshake (result, cout travel with it)
//   busy : engine is occupied with an operation (shifting or holding a result)
// master = producer/consumer side, slave = the arithmetic engine.
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, op, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, cout, busy
    );

    modport slave (
        input  in_valid, op, op_a, op_b, out_ready,
        output in_ready, out_valid, result, cout, busy
    );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder and one full-subtractor
// cell share a carry/borrow flip-flop and process the operands LSB-first, one
// bit per clock. Operands enter on the in_* handshake; WIDTH clocks later the
// result and final carry/borrow are offered on the out_* handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_addsub_if.slave (operand, result and busy signals)
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_addsub_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               op_q;
    logic               ff_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic               accept_c;
    logic               last_c;
    logic               sum_c;
    logic               carry_c;
    logic               in_ready_d;
    logic               out_valid_d;
    logic               busy_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)      state_d = SHIFT;
            SHIFT:   if (last_c)        state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Output/datapath decode: serial arithmetic cell and next handshake flags
    always_comb begin
        accept_c    = 1'b0;
        last_c      = 1'b0;
        sum_c       = 1'b0;
        carry_c     = 1'b0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;

        accept_c = (state_q == IDLE) && bus.in_valid && in_ready_q;
        last_c   = (state_q == SHIFT) && (cnt_q == LAST_BIT);

        sum_c = a_q[0] ^ b_q[0] ^ ff_q;
        if (op_q) begin
            // Full subtractor: borrow out of a - b - borrow_in
            carry_c = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & ff_q);
        end else begin
            carry_c = (a_q[0] & b_q[0]) | (b_q[0] & ff_q) | (a_q[0] & ff_q);
        end

        // Handshake flags are registered, so they are decoded from the next state
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // Handshake flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Operand shift registers, carry/borrow FF, bit counter and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
            ff_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        a_q   <= bus.op_a;
                        b_q   <= bus.op_b;
                        op_q  <= bus.op;
                        ff_q  <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    ff_q     <= carry_c;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    // New bit enters at the MSB so the LSB ends up at bit 0
                    result_q <= {sum_c, result_q[WIDTH-1:1]};
                    if (last_c) begin
                        cout_q <= carry_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): a transaction-level model
// predicts handshake flags, latency and arithmetic results every cycle, and
// directed vectors pin the model with hand-computed values.
module tb_serial_addsub;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned MAXLAT = 4 * WIDTH;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(WIDTH)) bus ();

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: pending operation, cycles since accept, expected values
    bit               m_pend = 1'b0;
    int               m_age  = 0;
    logic [WIDTH-1:0] m_res;
    logic             m_cout;
    bit               m_hold = 1'b0;
    logic [WIDTH-1:0] m_last;
    logic             m_lastc;

    // Compare process: checks the DUT every cycle, then advances the model
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst in_ready", 33'(bus.in_ready), 33'(1));
            chk("rst out_valid", 33'(bus.out_valid), 33'(0));
            chk("rst busy", 33'(bus.busy), 33'(0));
            chk("rst result", 33'(bus.result), 33'(0));
            chk("rst cout", 33'(bus.cout), 33'(0));
            m_pend  = 1'b0;
            m_age   = 0;
            m_hold  = 1'b1;
            m_last  = '0;
            m_lastc = 1'b0;
        end else begin
            chk("in_ready", 33'(bus.in_ready), 33'(!m_pend));
            chk("busy", 33'(bus.busy), 33'(m_pend));
            chk("out_valid", 33'(bus.out_valid), 33'(m_pend && (m_age >= int'(WIDTH))));
            if (m_pend && (m_age >= int'(WIDTH))) begin
                chk("result", 33'(bus.result), 33'(m_res));
                chk("cout", 33'(bus.cout), 33'(m_cout));
            end else if (!m_pend && m_hold) begin
                chk("held result", 33'(bus.result), 33'(m_last));
                chk("held cout", 33'(bus.cout), 33'(m_lastc));
            end

            if (!m_pend) begin
                if (bus.in_valid) begin
                    m_pend = 1'b1;
                    m_age  = 0;
                    m_hold = 1'b0;
                    if (bus.op) begin
                        m_res  = WIDTH'(bus.op_a - bus.op_b);
                        m_cout = (bus.op_a < bus.op_b);
                    end else begin
                        m_res  = WIDTH'(bus.op_a + bus.op_b);
                        m_cout = ((32'(bus.op_a) + 32'(bus.op_b)) >= (32'(1) << WIDTH));
                    end
                end
            end else if (m_age >= int'(WIDTH)) begin
                if (bus.out_ready) begin
                    m_pend  = 1'b0;
                    m_hold  = 1'b1;
                    m_last  = m_res;
                    m_lastc = m_cout;
                end
            end else begin
                m_age++;
            end
        end
    end

    // Wait for the operand handshake, then drop in_valid
    task automatic accept_wait();
        bit ok = 1'b0;
        for (int i = 0; i < int'(MAXLAT); i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept timeout", 33'(0), 33'(1));
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
    endtask

    // Present operands; with hold set, in_valid stays high after the accept
    task automatic send(input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit hold);
        bit ok = 1'b0;
        @(posedge clk);
        #2;
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.op_a     = a;
        bus.op_b     = b;
        if (hold) begin
            for (int i = 0; i < int'(MAXLAT); i++) begin
                @(negedge clk);
                if (bus.in_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) chk("accept timeout", 33'(0), 33'(1));
            @(posedge clk);
            #2;
        end else begin
            accept_wait();
        end
    endtask

    // Measure latency from the accept edge, check literal result, hold for gap cycles
    task automatic wait_out(input string tag, input logic [WIDTH-1:0] er, input logic ec,
                            input int gap);
        int lat  = 0;
        bit seen = 1'b0;
        for (int i = 0; i < int'(MAXLAT); i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, " latency"}, 33'(seen ? lat : 0), 33'(WIDTH));
        chk({tag, " result"}, 33'(bus.result), 33'(er));
        chk({tag, " cout"}, 33'(bus.cout), 33'(ec));
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
            chk({tag, " stall valid"}, 33'(bus.out_valid), 33'(1));
            chk({tag, " stall result"}, 33'(bus.result), 33'(er));
            chk({tag, " stall cout"}, 33'(bus.cout), 33'(ec));
        end
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " idle after handshake"}, 33'(bus.in_ready), 33'(1));
        chk({tag, " valid drop"}, 33'(bus.out_valid), 33'(0));
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Directed vectors
        send(1'b0, 8'hFF, 8'h01, 1'b0);
        wait_out("add FF+01", 8'h00, 1'b1, 0);
        send(1'b1, 8'h05, 8'h07, 1'b0);
        wait_out("sub 05-07", 8'hFE, 1'b1, 0);
        send(1'b1, 8'h80, 8'h80, 1'b0);
        wait_out("sub 80-80", 8'h00, 1'b0, 0);
        send(1'b0, 8'h3C, 8'h45, 1'b0);
        wait_out("add 3C+45 stall", 8'h81, 1'b0, 5);

        // in_valid held high with different operands while busy
        send(1'b1, 8'h0A, 8'h03, 1'b1);
        bus.op   = 1'b0;
        bus.op_a = 8'hF0;
        bus.op_b = 8'h20;
        wait_out("sub 0A-03 held", 8'h07, 1'b0, 2);
        accept_wait();
        wait_out("add F0+20 queued", 8'h10, 1'b1, 0);

        // Reset in the middle of SHIFT
        send(1'b0, 8'h12, 8'h34, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 33'(bus.out_valid), 33'(0));
        chk("async rst in_ready", 33'(bus.in_ready), 33'(1));
        chk("async rst busy", 33'(bus.busy), 33'(0));
        chk("async rst result", 33'(bus.result), 33'(0));
        chk("async rst cout", 33'(bus.cout), 33'(0));
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2 * WIDTH) @(posedge clk);
        send(1'b1, 8'h00, 8'h01, 1'b0);
        wait_out("sub 00-01 after rst", 8'hFF, 1'b1, 0);

        // Random operations with random consumer stalls
        for (int n = 0; n < 1000; n++) begin
            bit done = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'b0);
            for (int i = 0; i < 200; i++) begin
                @(posedge clk);
                #2;
                bus.out_ready = ($urandom_range(0, 2) == 0);
                @(negedge clk);
                if (bus.out_valid && bus.out_ready) begin
                    done = 1'b1;
                    break;
                end
            end
            if (!done) chk("random handshake timeout", 33'(0), 33'(1));
            @(posedge clk);
            #2;
            bus.out_ready = 1'b0;
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
